// File: rtl/i2c_reg_slave.sv
// i2c_reg_slave: I2C slave exposing NUM_REGS 8-bit registers with a
// register pointer, burst write/read, repeated START and pointer wrap.
`timescale 1ns/1ps
module i2c_reg_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h56,
  parameter int         NUM_REGS   = 4,
  localparam int        PTR_W      = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  scl,
  inout  wire                   sda,
  output logic [NUM_REGS*8-1:0] reg_out,
  output logic                  wr_strobe,
  output logic [PTR_W-1:0]      wr_index,
  output logic                  debug_addr_match,
  output logic [3:0]            debug_state
);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    RX_ADDR   = 4'd1,
    ADDR_ACK  = 4'd2,
    RX_PTR    = 4'd3,
    PTR_ACK   = 4'd4,
    RX_DATA   = 4'd5,
    DATA_ACK  = 4'd6,
    TX_DATA   = 4'd7,
    TX_ACK    = 4'd8,
    WAIT_STOP = 4'd9
  } state_t;

  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_REGS - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [2:0]       r_scl_sync;
  logic [2:0]       r_sda_sync;
  logic [7:0]       r_shift;
  logic [7:0]       r_tx_shift;
  logic [3:0]       r_bit_cnt;
  logic             r_ack_on;
  logic             r_got_ack;
  logic             r_sda_low;
  logic             r_addr_match;
  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] r_wr_index;
  logic             r_wr_strobe;
  logic [7:0]       r_regs [NUM_REGS];

  logic             w_scl_rise;
  logic             w_scl_fall;
  logic             w_start;
  logic             w_stop;
  logic             w_sda_in;
  logic             w_addr_match;
  logic             w_ptr_ok;
  logic [PTR_W-1:0] w_ptr_inc;

  // Bus pins are metastable-prone; idle level is high so reset to 1s to
  // avoid false edges when reset is released on an idle bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scl_sync <= 3'b111;
      r_sda_sync <= 3'b111;
    end else begin
      r_scl_sync <= {r_scl_sync[1:0], scl};
      r_sda_sync <= {r_sda_sync[1:0], sda};
    end
  end

  assign w_scl_rise   = r_scl_sync[1] & ~r_scl_sync[2];
  assign w_scl_fall   = ~r_scl_sync[1] & r_scl_sync[2];
  assign w_start      = r_sda_sync[2] & ~r_sda_sync[1] & r_scl_sync[1];
  assign w_stop       = ~r_sda_sync[2] & r_sda_sync[1] & r_scl_sync[1];
  assign w_sda_in     = r_sda_sync[1];
  assign w_addr_match = (r_shift[7:1] == SLAVE_ADDR);
  assign w_ptr_ok     = (r_shift < 8'(NUM_REGS));
  assign w_ptr_inc    = (r_ptr == LAST_PTR) ? '0 : r_ptr + PTR_W'(1);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state logic; STOP and START override every non-idle state.
  always_comb begin
    w_state_next = r_state;
    if (w_stop) begin
      w_state_next = IDLE;
    end else if (w_start) begin
      w_state_next = RX_ADDR;
    end else begin
      case (r_state)
        RX_ADDR:  if (w_scl_rise && r_bit_cnt == 4'd7) w_state_next = ADDR_ACK;
        ADDR_ACK: if (w_scl_fall) begin
                    if (!r_ack_on) begin
                      if (!w_addr_match) w_state_next = WAIT_STOP;
                    end else begin
                      w_state_next = r_shift[0] ? TX_DATA : RX_PTR;
                    end
                  end
        RX_PTR:   if (w_scl_rise && r_bit_cnt == 4'd7) w_state_next = PTR_ACK;
        PTR_ACK:  if (w_scl_fall) begin
                    if (!r_ack_on) begin
                      if (!w_ptr_ok) w_state_next = WAIT_STOP;
                    end else begin
                      w_state_next = RX_DATA;
                    end
                  end
        RX_DATA:  if (w_scl_rise && r_bit_cnt == 4'd7) w_state_next = DATA_ACK;
        DATA_ACK: if (w_scl_fall && r_ack_on) w_state_next = RX_DATA;
        TX_DATA:  if (w_scl_fall && r_bit_cnt == 4'd8) w_state_next = TX_ACK;
        TX_ACK:   if (w_scl_rise && w_sda_in) w_state_next = WAIT_STOP;
                  else if (w_scl_fall && r_got_ack) w_state_next = TX_DATA;
        default:  w_state_next = r_state;
      endcase
    end
  end

  // Datapath: shifting, ACK/data drive, pointer and register file updates.
  // SDA only ever changes on the clk after a detected SCL falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift      <= '0;
      r_tx_shift   <= '0;
      r_bit_cnt    <= '0;
      r_ack_on     <= 1'b0;
      r_got_ack    <= 1'b0;
      r_sda_low    <= 1'b0;
      r_addr_match <= 1'b0;
      r_ptr        <= '0;
      r_wr_index   <= '0;
      r_wr_strobe  <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      r_wr_strobe <= 1'b0;
      if (w_stop || w_start) begin
        // Any partial byte is dropped; pointer is retained.
        r_sda_low    <= 1'b0;
        r_addr_match <= 1'b0;
        r_bit_cnt    <= '0;
        r_ack_on     <= 1'b0;
        r_got_ack    <= 1'b0;
      end else begin
        case (r_state)
          RX_ADDR, RX_PTR, RX_DATA: begin
            if (w_scl_rise) begin
              r_shift   <= {r_shift[6:0], w_sda_in};
              r_bit_cnt <= (r_bit_cnt == 4'd7) ? 4'd0 : r_bit_cnt + 4'd1;
            end
          end
          ADDR_ACK: begin
            if (w_scl_fall) begin
              if (!r_ack_on) begin
                if (w_addr_match) begin
                  r_sda_low    <= 1'b1;
                  r_ack_on     <= 1'b1;
                  r_addr_match <= 1'b1;
                end
              end else begin
                r_ack_on  <= 1'b0;
                r_bit_cnt <= '0;
                if (r_shift[0]) begin
                  // Read: latch the byte and present its MSB right away.
                  r_tx_shift <= r_regs[r_ptr];
                  r_sda_low  <= ~r_regs[r_ptr][7];
                end else begin
                  r_sda_low <= 1'b0;
                end
              end
            end
          end
          PTR_ACK: begin
            if (w_scl_fall) begin
              if (!r_ack_on) begin
                if (w_ptr_ok) begin
                  r_sda_low <= 1'b1;
                  r_ack_on  <= 1'b1;
                  r_ptr     <= r_shift[PTR_W-1:0];
                end
              end else begin
                r_ack_on  <= 1'b0;
                r_sda_low <= 1'b0;
              end
            end
          end
          DATA_ACK: begin
            if (w_scl_fall) begin
              if (!r_ack_on) begin
                r_sda_low <= 1'b1;
                r_ack_on  <= 1'b1;
              end else begin
                r_ack_on      <= 1'b0;
                r_sda_low     <= 1'b0;
                r_regs[r_ptr] <= r_shift;
                r_wr_strobe   <= 1'b1;
                r_wr_index    <= r_ptr;
                r_ptr         <= w_ptr_inc;
              end
            end
          end
          TX_DATA: begin
            if (w_scl_rise) begin
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end else if (w_scl_fall) begin
              if (r_bit_cnt == 4'd8) begin
                r_sda_low <= 1'b0;
                r_bit_cnt <= '0;
                r_got_ack <= 1'b0;
              end else begin
                r_tx_shift <= {r_tx_shift[6:0], 1'b0};
                r_sda_low  <= ~r_tx_shift[6];
              end
            end
          end
          TX_ACK: begin
            if (w_scl_rise) begin
              r_got_ack <= ~w_sda_in;
            end else if (w_scl_fall && r_got_ack) begin
              r_got_ack  <= 1'b0;
              r_ptr      <= w_ptr_inc;
              r_tx_shift <= r_regs[w_ptr_inc];
              r_sda_low  <= ~r_regs[w_ptr_inc][7];
              r_bit_cnt  <= '0;
            end
          end
          WAIT_STOP: r_sda_low <= 1'b0;
          default:   r_sda_low <= 1'b0;
        endcase
      end
    end
  end

  // Open-drain output: only ever pull low.
  assign sda = r_sda_low ? 1'b0 : 1'bz;

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg_out
      assign reg_out[gi*8 +: 8] = r_regs[gi];
    end
  endgenerate

  assign wr_strobe        = r_wr_strobe;
  assign wr_index         = r_wr_index;
  assign debug_addr_match = r_addr_match;
  assign debug_state      = r_state;

endmodule
